// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle staged shifter (16/8/4/2/1) with start/busy/ready handshake
// One stage per clock in descending order; latency is fixed at SHW+1 cycles regardless of shamt.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic             busy_o,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int IW = (SHW > 1) ? $clog2(SHW) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       op_q, op_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [SHW-1:0]     shift_amt;
    logic [2*WIDTH-1:0] sra_ext;
    logic [WIDTH-1:0]   stage_val;

    // Stage k = 2**idx; SRA sign-fills from the current MSB, which never changes under SRA.
    always_comb begin
        shift_amt = SHW'(1) << idx_q;
        sra_ext   = {{WIDTH{acc_q[WIDTH-1]}}, acc_q} >> shift_amt;
        case (op_q)
            2'b00:   stage_val = acc_q << shift_amt;
            2'b10:   stage_val = acc_q >> shift_amt;
            default: stage_val = sra_ext[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_BUSY;
                    acc_d   = data_in_i;
                    op_d    = op_i;
                    shamt_d = shamt_i;
                    idx_d   = IW'(SHW - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (shamt_q[idx_q]) begin
                    acc_d = stage_val;
                end
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            idx_q   <= idx_d;
        end
    end

    assign busy_o       = (state_q == ST_BUSY);
    assign data_ready_o = (state_q == ST_DONE);
    assign result_o     = acc_q;

endmodule
